// File: rtl/led_run_decoder_pkg.sv
// Shared types and constants for the LED run decoder: FSM states, default
// geometry, the run record and the lengths a valid snake frame must contain.
package led_run_decoder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_POS_W = $clog2(DEF_WIDTH);
  localparam int DEF_LEN_W = $clog2(DEF_WIDTH) + 1;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH / 2) + 1;

  // The animator draws exactly one snake of each of these lengths.
  localparam int RUN_LEN_A = 1;
  localparam int RUN_LEN_B = 2;
  localparam int RUN_LEN_C = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_POS_W-1:0] pos;
    logic [DEF_LEN_W-1:0] len;
  } run_t;

endpackage

// File: rtl/led_run_if.sv
// Frame-in / results-out handshake bundle between the LED bus and the decoder.
interface led_run_if import led_run_decoder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int POS_W = $clog2(WIDTH);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int CNT_W = $clog2(WIDTH / 2) + 1;

  logic             frame_valid;
  logic [WIDTH-1:0] frame;
  logic             frame_ready;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] run_count;
  logic [POS_W-1:0] run0_pos;
  logic [POS_W-1:0] run1_pos;
  logic [POS_W-1:0] run2_pos;
  logic [LEN_W-1:0] run0_len;
  logic [LEN_W-1:0] run1_len;
  logic [LEN_W-1:0] run2_len;
  logic             overflow;
  logic             pattern_ok;

  modport master (
    output frame_valid, frame, result_ready,
    input  frame_ready, result_valid, run_count,
    input  run0_pos, run1_pos, run2_pos, run0_len, run1_len, run2_len,
    input  overflow, pattern_ok
  );

  modport slave (
    input  frame_valid, frame, result_ready,
    output frame_ready, result_valid, run_count,
    output run0_pos, run1_pos, run2_pos, run0_len, run1_len, run2_len,
    output overflow, pattern_ok
  );

endinterface

// File: rtl/led_run_decoder_tracker.sv
// Current-run accumulator: follows one bit per step and strobes a closed
// run's {pos, len} combinationally on the step that ends it.
module led_run_tracker #(
  parameter int POS_W = 4,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic             bit_in,
  input  logic [POS_W-1:0] index,
  input  logic             last,
  output logic             close,
  output logic [POS_W-1:0] close_pos,
  output logic [LEN_W-1:0] close_len
);

  logic             open_reg;
  logic [POS_W-1:0] pos_reg;
  logic [LEN_W-1:0] len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_reg <= 1'b0;
      pos_reg  <= '0;
      len_reg  <= '0;
    end else if (clear) begin
      open_reg <= 1'b0;
      pos_reg  <= '0;
      len_reg  <= '0;
    end else if (step) begin
      if (bit_in) begin
        if (open_reg) begin
          len_reg <= len_reg + LEN_W'(1);
        end else begin
          open_reg <= 1'b1;
          pos_reg  <= index;
          len_reg  <= LEN_W'(1);
        end
      end else begin
        open_reg <= 1'b0;
      end
    end
  end

  // A run reaching bit 0 closes on that same step, including its final bit.
  always_comb begin
    close     = 1'b0;
    close_pos = pos_reg;
    close_len = len_reg;
    if (step) begin
      if (open_reg && !bit_in) begin
        close = 1'b1;
      end else if (last && bit_in) begin
        close = 1'b1;
        if (open_reg) begin
          close_len = len_reg + LEN_W'(1);
        end else begin
          close_pos = index;
          close_len = LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/led_run_decoder.sv
// Serial MSB-first decoder recovering the leftmost three runs of ones in an
// LED frame, with run count, overflow and snake-pattern validity.
module led_run_decoder import led_run_decoder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  led_run_if.slave bus
);

  localparam int POS_W = $clog2(WIDTH);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int CNT_W = $clog2(WIDTH / 2) + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [POS_W-1:0] index_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [POS_W-1:0] slot_pos_reg [3];
  logic [LEN_W-1:0] slot_len_reg [3];
  logic [POS_W-1:0] slot_pos_next [3];
  logic [LEN_W-1:0] slot_len_next [3];
  logic [POS_W-1:0] res_pos_reg [3];
  logic [LEN_W-1:0] res_len_reg [3];
  logic [CNT_W-1:0] res_count_reg;
  logic             res_overflow_reg, res_pattern_reg;

  logic             accept, scan, last;
  logic             close;
  logic [POS_W-1:0] close_pos;
  logic [LEN_W-1:0] close_len;
  logic             has_a, has_b, has_c, pattern_next;

  assign accept = (state_reg == IDLE) && bus.frame_valid;
  assign scan   = (state_reg == SCAN);
  assign last   = (index_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.frame_valid) state_next = SCAN;
      SCAN:    if (last) state_next = DONE;
      DONE:    if (bus.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.frame_ready  = (state_reg == IDLE);
    bus.result_valid = (state_reg == DONE);
  end

  led_run_tracker #(.POS_W(POS_W), .LEN_W(LEN_W)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .step      (scan),
    .bit_in    (shift_reg[WIDTH-1]),
    .index     (index_reg),
    .last      (last),
    .close     (close),
    .close_pos (close_pos),
    .close_len (close_len)
  );

  assign count_next = count_reg + {{(CNT_W-1){1'b0}}, close};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      index_reg <= '0;
      count_reg <= '0;
    end else if (accept) begin
      shift_reg <= bus.frame;
      index_reg <= POS_W'(WIDTH - 1);
      count_reg <= '0;
    end else if (scan) begin
      shift_reg <= shift_reg << 1;
      index_reg <= index_reg - POS_W'(1);
      count_reg <= count_next;
    end
  end

  // Only the first three closed runs land in a slot; later ones just count.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    always_comb begin
      slot_pos_next[gi] = slot_pos_reg[gi];
      slot_len_next[gi] = slot_len_reg[gi];
      if (close && count_reg == CNT_W'(gi)) begin
        slot_pos_next[gi] = close_pos;
        slot_len_next[gi] = close_len;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_pos_reg[gi] <= '0;
        slot_len_reg[gi] <= '0;
        res_pos_reg[gi]  <= '0;
        res_len_reg[gi]  <= '0;
      end else if (accept) begin
        slot_pos_reg[gi] <= '0;
        slot_len_reg[gi] <= '0;
      end else if (scan) begin
        slot_pos_reg[gi] <= slot_pos_next[gi];
        slot_len_reg[gi] <= slot_len_next[gi];
        if (last) begin
          res_pos_reg[gi] <= slot_pos_next[gi];
          res_len_reg[gi] <= slot_len_next[gi];
        end
      end
    end
  end

  always_comb begin
    has_a = 1'b0;
    has_b = 1'b0;
    has_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot_len_next[i] == LEN_W'(RUN_LEN_A)) has_a = 1'b1;
      if (slot_len_next[i] == LEN_W'(RUN_LEN_B)) has_b = 1'b1;
      if (slot_len_next[i] == LEN_W'(RUN_LEN_C)) has_c = 1'b1;
    end
    pattern_next = (count_next == CNT_W'(3)) && has_a && has_b && has_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_count_reg    <= '0;
      res_overflow_reg <= 1'b0;
      res_pattern_reg  <= 1'b0;
    end else if (scan && last) begin
      res_count_reg    <= count_next;
      res_overflow_reg <= (count_next > CNT_W'(3));
      res_pattern_reg  <= pattern_next;
    end
  end

  assign bus.run_count  = res_count_reg;
  assign bus.run0_pos   = res_pos_reg[0];
  assign bus.run1_pos   = res_pos_reg[1];
  assign bus.run2_pos   = res_pos_reg[2];
  assign bus.run0_len   = res_len_reg[0];
  assign bus.run1_len   = res_len_reg[1];
  assign bus.run2_len   = res_len_reg[2];
  assign bus.overflow   = res_overflow_reg;
  assign bus.pattern_ok = res_pattern_reg;

endmodule

// File: tb/tb_led_run_decoder.sv
// Randomized and directed bench for led_run_decoder against a run-list model.
module tb_led_run_decoder;
  import led_run_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   exp_cnt;
  run_t exp_run [3];
  bit   exp_ov, exp_pok;

  led_run_if #(.WIDTH(16)) bus ();

  led_run_decoder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Walk the frame as a list of runs; lengths {1,2,3} <=> sum 6 and product 6.
  task automatic model(input logic [15:0] f);
    int i, start, l, sum, prod;
    exp_cnt = 0;
    for (int k = 0; k < 3; k++) exp_run[k] = '0;
    i = 15;
    while (i >= 0) begin
      if (f[i]) begin
        start = i;
        l = 0;
        while (i >= 0 && f[i]) begin
          l++;
          i--;
        end
        if (exp_cnt < 3) begin
          exp_run[exp_cnt].pos = DEF_POS_W'(start);
          exp_run[exp_cnt].len = DEF_LEN_W'(l);
        end
        exp_cnt++;
      end else begin
        i--;
      end
    end
    sum = 0;
    prod = 1;
    for (int k = 0; k < 3; k++) begin
      sum  += int'(exp_run[k].len);
      prod *= int'(exp_run[k].len);
    end
    exp_ov  = (exp_cnt > 3);
    exp_pok = (exp_cnt == 3) && (sum == 6) && (prod == 6);
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".count"}, 32'(bus.run_count), 32'(exp_cnt));
    check({tag, ".pos0"}, 32'(bus.run0_pos), 32'(exp_run[0].pos));
    check({tag, ".len0"}, 32'(bus.run0_len), 32'(exp_run[0].len));
    check({tag, ".pos1"}, 32'(bus.run1_pos), 32'(exp_run[1].pos));
    check({tag, ".len1"}, 32'(bus.run1_len), 32'(exp_run[1].len));
    check({tag, ".pos2"}, 32'(bus.run2_pos), 32'(exp_run[2].pos));
    check({tag, ".len2"}, 32'(bus.run2_len), 32'(exp_run[2].len));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ov));
    check({tag, ".pattern_ok"}, 32'(bus.pattern_ok), 32'(exp_pok));
  endtask

  task automatic offer(input logic [15:0] f);
    @(negedge clk);
    check("offer.frame_ready", 32'(bus.frame_ready), 32'd1);
    bus.frame_valid = 1'b1;
    bus.frame = f;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    bus.frame = 16'($urandom);
  endtask

  // Called just after the accept edge; result must appear 16 edges later.
  task automatic wait_result(input logic [15:0] f);
    int n = 0;
    while (!bus.result_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd16);
    model(f);
    check_fields("result");
    $display("frame=%04h runs=%0d r0=(%0d,%0d) r1=(%0d,%0d) r2=(%0d,%0d) ov=%0d ok=%0d",
             f, bus.run_count, bus.run0_pos, bus.run0_len, bus.run1_pos, bus.run1_len,
             bus.run2_pos, bus.run2_len, bus.overflow, bus.pattern_ok);
  endtask

  task automatic ack(input int delay);
    for (int d = 0; d < delay; d++) @(negedge clk);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check("ack.result_valid", 32'(bus.result_valid), 32'd0);
    check("ack.frame_ready", 32'(bus.frame_ready), 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] f, input int delay);
    offer(f);
    wait_result(f);
    ack(delay);
  endtask

  initial begin
    logic [15:0] directed [4];
    logic [15:0] f;
    directed[0] = 16'h8C07;
    directed[1] = 16'h0000;
    directed[2] = 16'hFFFF;
    directed[3] = 16'hAAAA;

    bus.frame_valid  = 1'b0;
    bus.frame        = '0;
    bus.result_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.frame_ready", 32'(bus.frame_ready), 32'd1);
    check("reset.result_valid", 32'(bus.result_valid), 32'd0);
    check("reset.count", 32'(bus.run_count), 32'd0);
    check("reset.overflow", 32'(bus.overflow), 32'd0);
    check("reset.pattern_ok", 32'(bus.pattern_ok), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) run_frame(directed[k], 0);

    for (int k = 0; k < 40; k++) begin
      f = (k % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      run_frame(f, int'($urandom_range(0, 3)));
    end

    // Back-pressure: results held, new frame offered but refused.
    offer(16'h8C07);
    wait_result(16'h8C07);
    @(negedge clk);
    bus.frame_valid = 1'b1;
    bus.frame = 16'h0007;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp.frame_ready", 32'(bus.frame_ready), 32'd0);
      check("bp.result_valid", 32'(bus.result_valid), 32'd1);
      check_fields("bp");
    end
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check("bp.release_ready", 32'(bus.frame_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    check("bp.accepted", 32'(bus.frame_ready), 32'd0);
    wait_result(16'h0007);
    ack(0);

    // Reset in the middle of a scan aborts at once.
    run_frame(16'h8C07, 0);
    offer(16'h0007);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.frame_ready", 32'(bus.frame_ready), 32'd1);
    check("abort.result_valid", 32'(bus.result_valid), 32'd0);
    check("abort.count", 32'(bus.run_count), 32'd0);
    check("abort.pos0", 32'(bus.run0_pos), 32'd0);
    check("abort.len0", 32'(bus.run0_len), 32'd0);
    check("abort.overflow", 32'(bus.overflow), 32'd0);
    check("abort.pattern_ok", 32'(bus.pattern_ok), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort.release_ready", 32'(bus.frame_ready), 32'd1);
    run_frame(16'h0007, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
